seg7_scan_driver: RTL and testbench

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_pkg.sv | 25 ++
 rtl/hex_to_7seg.sv | 32 +++
 rtl/seg7_scan_driver.sv | 151 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display blocks.
// Segment patterns are abcdefg, active-high, with segment a at bit 6.
package seg7_pkg;

  localparam int unsigned SEG_W    = 7;
  localparam int unsigned NIBBLE_W = 4;

  localparam logic [SEG_W-1:0] SEG_0 = 7'b1111110;
  localparam logic [SEG_W-1:0] SEG_1 = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_2 = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_3 = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_4 = 7'b0110011;
  localparam logic [SEG_W-1:0] SEG_5 = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_6 = 7'b1011111;
  localparam logic [SEG_W-1:0] SEG_7 = 7'b1110000;
  localparam logic [SEG_W-1:0] SEG_8 = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9 = 7'b1111011;
  localparam logic [SEG_W-1:0] SEG_A = 7'b1110111;
  localparam logic [SEG_W-1:0] SEG_B = 7'b0011111;
  localparam logic [SEG_W-1:0] SEG_C = 7'b1001110;
  localparam logic [SEG_W-1:0] SEG_D = 7'b0111101;
  localparam logic [SEG_W-1:0] SEG_E = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_F = 7'b1000111;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to seven-segment pattern decoder.
module hex_to_7seg
  import seg7_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble,
  output logic [SEG_W-1:0]    seg
);

  always_comb begin
    seg = SEG_0;
    unique case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver with shadow-buffered, tear-free updates,
// anti-ghost blanking at each slot start and optional leading-zero suppression.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned REFRESH_DIV   = 50000,
  parameter int unsigned BLANK_CYC     = 2,
  parameter bit          AN_ACTIVE_LOW = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         load,
  input  logic [NIBBLE_W*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]            dp_in,
  input  logic                         lz_suppress,
  output logic [SEG_W-1:0]             seg,
  output logic                         dp_out,
  output logic [DIGITS-1:0]            an,
  output logic                         frame_done
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam int unsigned DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0]     PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0]     DIG_LAST = DW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_OFF   = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [PW-1:0]                presc_q, presc_d;
  logic [DW-1:0]                digit_q, digit_d;
  logic [NIBBLE_W*DIGITS-1:0]   shadow_val_q, shadow_val_d;
  logic [DIGITS-1:0]            shadow_dp_q, shadow_dp_d;
  logic                         pending_q, pending_d;
  logic [NIBBLE_W*DIGITS-1:0]   disp_val_q, disp_val_d;
  logic [DIGITS-1:0]            disp_dp_q, disp_dp_d;
  logic [SEG_W-1:0]             seg_q, seg_d;
  logic                         dp_q, dp_d;
  logic [DIGITS-1:0]            an_q, an_d;

  logic                         slot_wrap;
  logic                         frame_wrap;
  logic [NIBBLE_W-1:0]          cur_nib;
  logic [SEG_W-1:0]             dec_seg;
  logic [DW-1:0]                hi_digit;
  logic                         suppress;
  logic                         blank;
  logic [DIGITS-1:0]            an_on;

  hex_to_7seg u_dec (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

  assign slot_wrap  = enable && (presc_q == PRE_LAST);
  assign frame_wrap = slot_wrap && (digit_q == DIG_LAST);
  assign cur_nib    = disp_val_q[digit_q*NIBBLE_W +: NIBBLE_W];
  assign blank      = 32'(presc_q) < BLANK_CYC;
  assign an_on      = DIGITS'(1) << digit_q;

  // Highest non-zero nibble; digit 0 is the floor so it is never suppressed.
  always_comb begin
    hi_digit = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (disp_val_q[i*NIBBLE_W +: NIBBLE_W] != '0) hi_digit = DW'(i);
    end
  end

  assign suppress = lz_suppress && (digit_q > hi_digit);

  always_comb begin
    presc_d      = presc_q;
    digit_d      = digit_q;
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    pending_d    = pending_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;

    if (enable) begin
      if (slot_wrap) begin
        presc_d = '0;
        digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + DW'(1);
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    if (load) begin
      shadow_val_d = value;
      shadow_dp_d  = dp_in;
      pending_d    = 1'b1;
    end

    // A load landing on the boundary itself wins over the older shadow contents.
    if (frame_wrap) begin
      pending_d = 1'b0;
      if (load) begin
        disp_val_d = value;
        disp_dp_d  = dp_in;
      end else if (pending_q) begin
        disp_val_d = shadow_val_q;
        disp_dp_d  = shadow_dp_q;
      end
    end
  end

  always_comb begin
    seg_d = '0;
    dp_d  = 1'b0;
    an_d  = AN_OFF;
    if (enable && !blank) begin
      an_d  = AN_ACTIVE_LOW ? ~an_on : an_on;
      seg_d = suppress ? '0 : dec_seg;
      dp_d  = disp_dp_q[digit_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q      <= '0;
      digit_q      <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      pending_q    <= 1'b0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      seg_q        <= '0;
      dp_q         <= 1'b0;
      an_q         <= AN_OFF;
    end else begin
      presc_q      <= presc_d;
      digit_q      <= digit_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      pending_q    <= pending_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
    end
  end

  assign seg        = seg_q;
  assign dp_out     = dp_q;
  assign an         = an_q;
  assign frame_done = frame_wrap;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIGITS=4, REFRESH_DIV=4, BLANK_CYC=1, active-low anodes.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        lz_suppress;
  logic [6:0]  seg;
  logic        dp_out;
  logic [3:0]  an;
  logic        frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  seg7_scan_driver #(
    .DIGITS        (4),
    .REFRESH_DIV   (4),
    .BLANK_CYC     (1),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .load        (load),
    .value       (value),
    .dp_in       (dp_in),
    .lz_suppress (lz_suppress),
    .seg         (seg),
    .dp_out      (dp_out),
    .an          (an),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Wait (bounded) for the negedge on which frame_done is high.
  task automatic sync_frame(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (frame_done) found = 1'b1;
    end
    check({tag, "_sync"}, 32'(found), 32'd1);
  endtask

  // Starting on a frame_done negedge, walk one full frame and check every slot.
  // Sample n reflects the scan state of cycle n-2 of the frame.
  task automatic check_frame(input string tag, input logic [27:0] exp_seg,
                             input logic [3:0] exp_dp, input int load_at,
                             input logic [15:0] lv, input logic [3:0] ldp);
    int s;
    int d;
    logic [3:0] ea;
    for (int n = 1; n <= 16; n++) begin
      if (n == load_at) begin
        load  = 1'b1;
        value = lv;
        dp_in = ldp;
      end
      @(negedge clk);
      load = 1'b0;
      if (n >= 2) begin
        s = n - 2;
        d = s / 4;
        if (s % 4 == 0) begin
          check({tag, "_blank_an"}, 32'(an), 32'hF);
          check({tag, "_blank_seg"}, 32'(seg), 32'h0);
          check({tag, "_blank_dp"}, 32'(dp_out), 32'h0);
        end else begin
          ea = ~(4'b0001 << d);
          check({tag, "_an"}, 32'(an), 32'(ea));
          check({tag, "_seg"}, 32'(seg), 32'(exp_seg[d*7 +: 7]));
          check({tag, "_dp"}, 32'(dp_out), 32'(exp_dp[d]));
        end
      end
      check({tag, "_frame_done"}, 32'(frame_done), (n == 16) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    enable      = 1'b1;
    load        = 1'b0;
    value       = '0;
    dp_in       = '0;
    lz_suppress = 1'b0;

    #1 rst = 1'b1;
    #1;
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h0);
    check("rst_dp", 32'(dp_out), 32'h0);
    check("rst_fd", 32'(frame_done), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    @(negedge clk);
    check("post_rst_blank", 32'(an), 32'hF);
    @(negedge clk);
    check("post_rst_an", 32'(an), 32'hE);
    check("post_rst_seg", 32'(seg), 32'h7E);

    // BEEF committed at the first frame boundary.
    load  = 1'b1;
    value = 16'hBEEF;
    dp_in = 4'b0000;
    @(negedge clk);
    load = 1'b0;
    sync_frame("beef");
    check_frame("beef", {7'h1F, 7'h4F, 7'h4F, 7'h47}, 4'b0000, 0, 16'h0, 4'h0);

    // Load on the boundary cycle commits immediately; mid-frame load waits a frame.
    check_frame("bnd_load", {4{7'h7E}}, 4'b0000, 1, 16'h0000, 4'b0000);
    check_frame("mid_load", {4{7'h7E}}, 4'b0000, 7, 16'h1234, 4'b0101);
    check_frame("new_frame", {7'h30, 7'h6D, 7'h79, 7'h33}, 4'b0101, 0, 16'h0, 4'h0);

    lz_suppress = 1'b1;
    check_frame("lz_a0", {7'h00, 7'h00, 7'h77, 7'h7E}, 4'b1000, 1, 16'h00A0, 4'b1000);
    check_frame("lz_zero", {7'h00, 7'h00, 7'h00, 7'h7E}, 4'b0000, 1, 16'h0000, 4'b0000);
    lz_suppress = 1'b0;

    // On a boundary cycle frame_done follows enable directly.
    enable = 1'b0;
    #1 check("fd_gated", 32'(frame_done), 32'd0);
    enable = 1'b1;
    #1 check("fd_ungated", 32'(frame_done), 32'd1);

    repeat (3) @(negedge clk);
    check("pre_hold_an", 32'(an), 32'hE);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_an", 32'(an), 32'hF);
      check("hold_seg", 32'(seg), 32'h0);
      check("hold_dp", 32'(dp_out), 32'h0);
      check("hold_fd", 32'(frame_done), 32'h0);
    end
    enable = 1'b1;
    @(negedge clk);
    check("resume_an0", 32'(an), 32'hE);
    @(negedge clk);
    check("resume_an1", 32'(an), 32'hE);
    @(negedge clk);
    check("resume_blank", 32'(an), 32'hF);
    @(negedge clk);
    check("resume_d1_an", 32'(an), 32'hD);
    check("resume_d1_seg", 32'(seg), 32'h7E);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("resume_fd_low", 32'(frame_done), 32'h0);
    end
    @(negedge clk);
    check("resume_fd_high", 32'(frame_done), 32'h1);

    // Asynchronous reset with a pending load mid-frame.
    repeat (6) @(negedge clk);
    load  = 1'b1;
    value = 16'h8888;
    dp_in = 4'b1111;
    @(negedge clk);
    load = 1'b0;
    check("pre_rst_an", 32'(an), 32'hD);
    #2 rst = 1'b1;
    #1;
    check("async_rst_an", 32'(an), 32'hF);
    check("async_rst_seg", 32'(seg), 32'h0);
    check("async_rst_dp", 32'(dp_out), 32'h0);
    check("async_rst_fd", 32'(frame_done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst2_blank", 32'(an), 32'hF);
    @(negedge clk);
    check("rst2_an", 32'(an), 32'hE);
    check("rst2_seg", 32'(seg), 32'h7E);
    check("rst2_dp", 32'(dp_out), 32'h0);
    sync_frame("rst2");
    check_frame("rst2_frame", {4{7'h7E}}, 4'b0000, 0, 16'h0, 4'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Guards the anode bus across the whole run.
  always @(negedge clk) begin
    if (!rst && ($countones(~an) > 1)) begin
      n_tests++;
      n_fail++;
      $display("FAIL multi_anode: got %0h expected at most one low bit", an);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
